load_store_unit: RTL

Memory-access stage of the DHRUT-V pipeline, sitting between Execute and Writeback. It takes the ALU result, store data, rd, func3 and opcode from Execute and drives a req/gnt/rvalid data-memory port with byte-lane alignment and load sign/zero extension. It returns the writeback value (also the forwarding value for Execute) and stalls upstream while a memory transaction is outstanding.

---
 rtl/load_store_unit.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: aligned dmem requests, store lanes, load extension
module load_store_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_valid,
  input  logic [31:0] i_result,
  input  logic [31:0] i_data_store,
  input  logic [4:0]  i_rd,
  input  logic [2:0]  i_func3,
  input  logic [6:0]  i_opcode,
  input  logic [31:0] i_pc,
  output logic        o_stall,
  output logic        o_dmem_req,
  output logic        o_dmem_we,
  output logic [31:0] o_dmem_addr,
  output logic [31:0] o_dmem_wdata,
  output logic [3:0]  o_dmem_be,
  input  logic        i_dmem_gnt,
  input  logic        i_dmem_rvalid,
  input  logic [31:0] i_dmem_rdata,
  output logic        o_wb_valid,
  output logic [31:0] o_wb_data,
  output logic [4:0]  o_rd,
  output logic        o_reg_write,
  output logic [31:0] o_pc,
  output logic        o_ls_fault,
  output logic [4:0]  o_rd_mem,
  output logic [31:0] o_mem_result
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;
  state_t state, state_next;

  logic [31:0] addr_q, wdata_q, pc_q;
  logic [3:0]  be_q;
  logic [2:0]  func3_q;
  logic [4:0]  rd_q;
  logic        we_q;

  logic        is_load, is_store, is_mem, func3_ok, misaligned, ls_fault;
  logic [31:0] st_wdata;
  logic [3:0]  st_be;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;

  // Decode and fault detection for the instruction presented by Execute
  always_comb begin
    is_load  = (i_opcode == OP_LOAD);
    is_store = (i_opcode == OP_STORE);
    is_mem   = is_load | is_store;
    func3_ok = 1'b0;
    if (is_load)
      func3_ok = (i_func3 == 3'b000) | (i_func3 == 3'b001) | (i_func3 == 3'b010) |
                 (i_func3 == 3'b100) | (i_func3 == 3'b101);
    else if (is_store)
      func3_ok = (i_func3 == 3'b000) | (i_func3 == 3'b001) | (i_func3 == 3'b010);
    misaligned = ((i_func3[1:0] == 2'b01) & i_result[0]) |
                 ((i_func3[1:0] == 2'b10) & (i_result[1:0] != 2'b00));
    ls_fault   = is_mem & (~func3_ok | misaligned);
  end

  always_comb begin
    st_wdata = i_data_store;
    st_be    = 4'b1111;
    case (i_func3[1:0])
      2'b00: begin
        st_wdata = {4{i_data_store[7:0]}};
        st_be    = 4'b0001 << i_result[1:0];
      end
      2'b01: begin
        st_wdata = {2{i_data_store[15:0]}};
        st_be    = i_result[1] ? 4'b1100 : 4'b0011;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = i_dmem_rdata[7:0];
      2'b01:   ld_byte = i_dmem_rdata[15:8];
      2'b10:   ld_byte = i_dmem_rdata[23:16];
      default: ld_byte = i_dmem_rdata[31:24];
    endcase
    ld_half = addr_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    case (func3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = i_dmem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (i_valid && is_mem && !ls_fault) state_next = S_REQ;
      S_REQ:  if (i_dmem_gnt) state_next = we_q ? S_IDLE : S_WAIT;
      S_WAIT: if (i_dmem_rvalid) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Transaction latches and the writeback register set
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
      func3_q     <= '0;
      rd_q        <= '0;
      pc_q        <= '0;
      we_q        <= 1'b0;
      o_wb_valid  <= 1'b0;
      o_wb_data   <= '0;
      o_rd        <= '0;
      o_reg_write <= 1'b0;
      o_pc        <= '0;
      o_ls_fault  <= 1'b0;
    end else begin
      o_wb_valid <= 1'b0;
      case (state)
        S_IDLE: if (i_valid) begin
          if (!is_mem || ls_fault) begin
            o_wb_valid  <= 1'b1;
            o_wb_data   <= i_result;
            o_rd        <= i_rd;
            o_pc        <= i_pc;
            o_reg_write <= !is_mem && (i_rd != 5'd0);
            o_ls_fault  <= ls_fault;
          end else begin
            addr_q  <= i_result;
            wdata_q <= st_wdata;
            be_q    <= st_be;
            func3_q <= i_func3;
            rd_q    <= i_rd;
            pc_q    <= i_pc;
            we_q    <= is_store;
          end
        end
        S_REQ: if (i_dmem_gnt && we_q) begin
          o_wb_valid  <= 1'b1;
          o_wb_data   <= addr_q;
          o_rd        <= rd_q;
          o_pc        <= pc_q;
          o_reg_write <= 1'b0;
          o_ls_fault  <= 1'b0;
        end
        S_WAIT: if (i_dmem_rvalid) begin
          o_wb_valid  <= 1'b1;
          o_wb_data   <= ld_data;
          o_rd        <= rd_q;
          o_pc        <= pc_q;
          o_reg_write <= (rd_q != 5'd0);
          o_ls_fault  <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_stall      = (state != S_IDLE);
  assign o_dmem_req   = (state == S_REQ);
  assign o_dmem_we    = (state == S_REQ) & we_q;
  assign o_dmem_be    = (state == S_REQ) ? be_q : 4'b0000;
  assign o_dmem_addr  = {addr_q[31:2], 2'b00};
  assign o_dmem_wdata = wdata_q;
  assign o_rd_mem     = (o_wb_valid && o_reg_write) ? o_rd : 5'd0;
  assign o_mem_result = o_wb_data;

endmodule
